// File: rtl/apple_iie_dram_bank_responder.sv
// Apple IIe main/aux 64K x 8 DRAM bank responder.
// Sits at the far end of the MMU's multiplexed RAM address bus: latches row and
// column from ra on falling pras_n / pcas_n, steers the access to the main or aux
// bank, returns read data on md_out and flags refresh and strobe-protocol errors.
module apple_iie_dram_bank_responder #(
  parameter int unsigned REFRESH_LIMIT = 28636,
  parameter int unsigned TRP_MIN       = 2
) (
  input  logic       clk_14m,
  input  logic       reset_n,
  input  logic [7:0] ra,
  input  logic       pras_n,
  input  logic       pcas_n,
  input  logic       rw_n,
  input  logic       ramen_n,
  input  logic       en80_n,
  input  logic [7:0] md_in,
  output logic [7:0] md_out,
  output logic       md_oe,
  output logic       refresh_err,
  output logic       protocol_err
);

  localparam int unsigned REF_W = $clog2(REFRESH_LIMIT + 1);
  localparam int unsigned PRE_W = $clog2(TRP_MIN + 1);
  localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_LIMIT);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TRP_MIN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROW    = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t           state, state_next;
  logic             prev_ras, prev_cas;
  logic [7:0]       row_q, col_q;
  logic             rw_q, ramen_q, en80_q;
  logic             first_q;
  logic [REF_W-1:0] ref_cnt;
  logic [PRE_W-1:0] pre_cnt;

  logic             ras_fall, ras_rise, cas_fall, cas_rise;
  logic             latch_row, latch_col, set_proto, do_read, clr_oe;
  logic             wr_main, wr_aux;
  logic             sel_one_q;
  logic [15:0]      wr_addr, rd_addr;

  logic [7:0]       main_mem [0:65535];
  logic [7:0]       aux_mem  [0:65535];

  assign ras_fall  =  prev_ras & ~pras_n;
  assign ras_rise  = ~prev_ras &  pras_n;
  assign cas_fall  =  prev_cas & ~pcas_n;
  assign cas_rise  = ~prev_cas &  pcas_n;

  // Cell address is {col, row}; a write uses the column present on ra at the CAS fall.
  assign wr_addr   = {ra, row_q};
  assign rd_addr   = {col_q, row_q};
  assign sel_one_q = ramen_q ^ en80_q;

  // Writes commit on the CAS-fall sampling edge; exactly one bank must be selected.
  assign wr_main   = latch_col & ~rw_n & ~ramen_n &  en80_n;
  assign wr_aux    = latch_col & ~rw_n &  ramen_n & ~en80_n;

  // FSM state register.
  always_ff @(posedge clk_14m or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_next = state;
    latch_row  = 1'b0;
    latch_col  = 1'b0;
    set_proto  = 1'b0;
    do_read    = 1'b0;
    clr_oe     = 1'b0;
    case (state)
      IDLE: begin
        if (ras_fall) begin
          latch_row  = 1'b1;
          state_next = ROW;
          if (pre_cnt < PRE_MAX) set_proto = 1'b1;  // short precharge, access still runs
        end
        if (cas_fall) set_proto = 1'b1;             // CAS-before-RAS is not supported
      end
      ROW: begin
        if (ras_rise) begin
          state_next = IDLE;                        // RAS-only refresh complete
        end else if (cas_fall) begin
          latch_col  = 1'b1;
          state_next = ACCESS;
          if (!ramen_n && !en80_n) set_proto = 1'b1; // both banks selected: no access
        end
      end
      ACCESS: begin
        if (ras_rise) begin
          clr_oe     = 1'b1;
          state_next = IDLE;
          if (!cas_rise) set_proto = 1'b1;          // RAS released while CAS still low
        end else if (cas_rise) begin
          clr_oe     = 1'b1;
          state_next = ROW;                         // page mode: row stays open
        end else if (first_q && rw_q && sel_one_q) begin
          do_read    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Strobe history, address/control latches and read data path.
  always_ff @(posedge clk_14m or negedge reset_n) begin
    if (!reset_n) begin
      prev_ras <= 1'b1;
      prev_cas <= 1'b1;
      row_q    <= 8'h00;
      col_q    <= 8'h00;
      rw_q     <= 1'b1;
      ramen_q  <= 1'b1;
      en80_q   <= 1'b1;
      first_q  <= 1'b0;
      md_out   <= 8'h00;
      md_oe    <= 1'b0;
    end else begin
      prev_ras <= pras_n;
      prev_cas <= pcas_n;
      first_q  <= latch_col;
      if (latch_row) row_q <= ra;
      if (latch_col) begin
        col_q   <= ra;
        rw_q    <= rw_n;
        ramen_q <= ramen_n;
        en80_q  <= en80_n;
      end
      if (clr_oe) begin
        md_oe <= 1'b0;
      end else if (do_read) begin
        md_out <= ramen_q ? aux_mem[rd_addr] : main_mem[rd_addr];
        md_oe  <= 1'b1;
      end
    end
  end

  // Bank arrays: write port only.
  always_ff @(posedge clk_14m) begin
    // NOTE: the arrays are deliberately not reset; DRAM contents are undefined at power-up.
    if (wr_main) main_mem[wr_addr] <= md_in;
    if (wr_aux)  aux_mem[wr_addr]  <= md_in;
  end

  // Refresh interval and precharge counters.
  always_ff @(posedge clk_14m or negedge reset_n) begin
    if (!reset_n) begin
      ref_cnt <= '0;
      pre_cnt <= '0;
    end else begin
      if (ras_fall)              ref_cnt <= '0;
      else if (ref_cnt != REF_MAX) ref_cnt <= ref_cnt + 1'b1;
      if (ras_fall)                        pre_cnt <= '0;
      else if (pras_n && pre_cnt != PRE_MAX) pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // Sticky error flags.
  always_ff @(posedge clk_14m or negedge reset_n) begin
    if (!reset_n) begin
      refresh_err  <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      if (!ras_fall && ref_cnt >= REF_MAX - 1'b1) refresh_err <= 1'b1;
      if (set_proto) protocol_err <= 1'b1;
    end
  end

endmodule
